// File: rtl/palette_fx_pkg.sv
// Shared types and constants for the palette/fade colour stage.
package palette_fx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    DARK,
    FADE_IN
  } fade_state_t;

  localparam logic [4:0] LEVEL_MAX = 5'd16;

  // Entry 0 is the rightmost word; each entry is {R, G, B}.
  localparam logic [15:0][11:0] PALETTE = {
    12'h763, 12'h763, 12'h763, 12'h763, 12'h763,
    12'h763, 12'h763, 12'h763, 12'h763, 12'h763,
    12'h442, 12'hF00, 12'hFD7, 12'h6DF, 12'h862, 12'h221
  };

endpackage

// File: rtl/palette_scale.sv
// Combinational brightness scaler: (colour * level) >> 4 for one 4-bit channel.
module palette_scale (
  input  logic [3:0] color_i,
  input  logic [4:0] level_i,
  output logic [3:0] color_o
);

  logic [8:0] product;
  logic       unused_product_msb;

  assign product            = {5'b0, color_i} * {4'b0, level_i};
  // 15 * 16 = 240, so bit 8 never sets for legal levels.
  assign unused_product_msb = product[8];
  assign color_o            = product[7:4];

endmodule

// File: rtl/palette_fade_ctrl.sv
// Palette lookup, vsync-aligned brightness fade sequencer and 2-stage colour pipeline.
// Optional hazard flash enabled with `PALETTE_FLASH_EN.
module palette_fade_ctrl
  import palette_fx_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned STEP            = 1,
  parameter int unsigned FLASH_FRAMES    = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vsync_pulse,
  input  logic       pix_valid,
  input  logic [3:0] pix_index,
  input  logic       fade_out_req,
  input  logic       fade_in_req,
  input  logic       flash_req,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       pix_valid_out,
  output logic       busy,
  output logic       fade_done
);

  localparam int unsigned CntW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAMES_PER_STEP - 1);
  localparam logic [4:0] StepLvl = 5'(STEP);

  fade_state_t     state_q, state_d;
  logic [4:0]      level_q, level_d;
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
  logic            fade_done_q, fade_done_d;

  logic [5:0] level_sum;
  logic [4:0] level_up, level_dn;
  logic       step_now;
  logic       flash_active;

  always_comb begin
    level_sum = {1'b0, level_q} + {1'b0, StepLvl};
    level_up  = (level_sum >= {1'b0, LEVEL_MAX}) ? LEVEL_MAX : level_sum[4:0];
    level_dn  = (level_q <= StepLvl) ? 5'd0 : level_q - StepLvl;
    step_now  = vsync_pulse && (frame_cnt_q == CntLast);
  end

  // A request that causes a transition suppresses any step on the same vsync.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    fade_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fade_out_req) begin
          state_d     = FADE_OUT;
          frame_cnt_d = '0;
        end
      end
      DARK: begin
        if (fade_in_req && !fade_out_req) begin
          state_d     = FADE_IN;
          frame_cnt_d = '0;
        end
      end
      FADE_OUT: begin
        if (fade_in_req && !fade_out_req) begin
          state_d     = FADE_IN;
          frame_cnt_d = '0;
        end else if (step_now) begin
          level_d     = level_dn;
          frame_cnt_d = '0;
          if (level_dn == 5'd0) begin
            state_d     = DARK;
            fade_done_d = 1'b1;
          end
        end else if (vsync_pulse) begin
          frame_cnt_d = frame_cnt_q + CntW'(1);
        end
      end
      FADE_IN: begin
        if (fade_out_req) begin
          state_d     = FADE_OUT;
          frame_cnt_d = '0;
        end else if (step_now) begin
          level_d     = level_up;
          frame_cnt_d = '0;
          if (level_up == LEVEL_MAX) begin
            state_d     = IDLE;
            fade_done_d = 1'b1;
          end
        end else if (vsync_pulse) begin
          frame_cnt_d = frame_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        level_d = LEVEL_MAX;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      level_q     <= LEVEL_MAX;
      frame_cnt_q <= '0;
      fade_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      fade_done_q <= fade_done_d;
    end
  end

`ifdef PALETTE_FLASH_EN
  localparam int unsigned FlashW = $clog2(FLASH_FRAMES + 1);

  logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (flash_req) begin
      flash_cnt_d = FlashW'(FLASH_FRAMES);
    end else if (vsync_pulse && (flash_cnt_q != '0)) begin
      flash_cnt_d = flash_cnt_q - FlashW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      flash_cnt_q <= '0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign flash_active = (flash_cnt_q != '0);
`else
  logic unused_flash;

  assign unused_flash = flash_req ^ (FLASH_FRAMES == 0);
  assign flash_active = 1'b0;
`endif

  // S1: palette lookup; the level is captured alongside so S2 scales with entry-time brightness.
  logic        s1_valid_q;
  logic [11:0] s1_rgb_q;
  logic [4:0]  s1_level_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      s1_rgb_q   <= '0;
      s1_level_q <= LEVEL_MAX;
    end else begin
      s1_valid_q <= pix_valid;
      s1_rgb_q   <= PALETTE[pix_index];
      s1_level_q <= level_q;
    end
  end

  logic [3:0] red_scaled, green_scaled, blue_scaled;
  logic [3:0] red_d, green_d, blue_d;
  logic [3:0] red_q, green_q, blue_q;
  logic       pix_valid_out_q;

  palette_scale u_scale_red (
    .color_i (s1_rgb_q[11:8]),
    .level_i (s1_level_q),
    .color_o (red_scaled)
  );

  palette_scale u_scale_green (
    .color_i (s1_rgb_q[7:4]),
    .level_i (s1_level_q),
    .color_o (green_scaled)
  );

  palette_scale u_scale_blue (
    .color_i (s1_rgb_q[3:0]),
    .level_i (s1_level_q),
    .color_o (blue_scaled)
  );

  always_comb begin
    red_d   = 4'h0;
    green_d = 4'h0;
    blue_d  = 4'h0;
    if (s1_valid_q) begin
      red_d   = flash_active ? 4'hF : red_scaled;
      green_d = green_scaled;
      blue_d  = blue_scaled;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      red_q           <= 4'h0;
      green_q         <= 4'h0;
      blue_q          <= 4'h0;
      pix_valid_out_q <= 1'b0;
    end else begin
      red_q           <= red_d;
      green_q         <= green_d;
      blue_q          <= blue_d;
      pix_valid_out_q <= s1_valid_q;
    end
  end

  assign red           = red_q;
  assign green         = green_q;
  assign blue          = blue_q;
  assign pix_valid_out = pix_valid_out_q;
  assign busy          = (state_q == FADE_OUT) || (state_q == FADE_IN);
  assign fade_done     = fade_done_q;

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Randomized bench for palette_fade_ctrl: two instances (FPS=2/STEP=1 and FPS=1/STEP=3)
// checked every cycle against a behavioural fade/pixel model.
module tb_palette_fade_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       vsync_pulse, pix_valid, fade_out_req, fade_in_req, flash_req;
  logic [3:0] pix_index;
  logic [3:0] red [2];
  logic [3:0] green [2];
  logic [3:0] blue [2];
  logic       pvo [2];
  logic       busy [2];
  logic       done [2];

  always #5 Clk = ~Clk;

  palette_fade_ctrl #(
    .FRAMES_PER_STEP (2),
    .STEP            (1),
    .FLASH_FRAMES    (8)
  ) u_dut_a (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .vsync_pulse   (vsync_pulse),
    .pix_valid     (pix_valid),
    .pix_index     (pix_index),
    .fade_out_req  (fade_out_req),
    .fade_in_req   (fade_in_req),
    .flash_req     (flash_req),
    .red           (red[0]),
    .green         (green[0]),
    .blue          (blue[0]),
    .pix_valid_out (pvo[0]),
    .busy          (busy[0]),
    .fade_done     (done[0])
  );

  palette_fade_ctrl #(
    .FRAMES_PER_STEP (1),
    .STEP            (3),
    .FLASH_FRAMES    (8)
  ) u_dut_b (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .vsync_pulse   (vsync_pulse),
    .pix_valid     (pix_valid),
    .pix_index     (pix_index),
    .fade_out_req  (fade_out_req),
    .fade_in_req   (fade_in_req),
    .flash_req     (flash_req),
    .red           (red[1]),
    .green         (green[1]),
    .blue          (blue[1]),
    .pix_valid_out (pvo[1]),
    .busy          (busy[1]),
    .fade_done     (done[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fps_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int pal_rgb(input int idx);
    case (idx)
      0:       return 'h221;
      1:       return 'h862;
      2:       return 'h6DF;
      3:       return 'hFD7;
      4:       return 'hF00;
      5:       return 'h442;
      default: return 'h763;
    endcase
  endfunction

  // Reference model: brightness as an integer with a direction of travel (-1/0/+1).
  int m_level [2];
  int m_dir [2];
  int m_frames [2];
  int m_done [2];
  int s1_v [2];
  int s1_rgb [2];
  int s1_lvl [2];
  int s2_v [2];
  int s2_c [2][3];
  int m_flash;
  int done_cnt [2];
  bit rand_pix = 1'b1;

  task automatic model_edge();
    int fl_pre;
    int moved;
    fl_pre = m_flash;
    for (int k = 0; k < 2; k++) begin
      s2_v[k] = s1_v[k];
      for (int ch = 0; ch < 3; ch++) begin
        s2_c[k][ch] = s1_v[k] ? (((s1_rgb[k] >> (8 - 4 * ch)) & 15) * s1_lvl[k]) / 16 : 0;
      end
`ifdef PALETTE_FLASH_EN
      if (s1_v[k] != 0 && fl_pre != 0) s2_c[k][0] = 15;
`endif
      s1_v[k]   = int'(pix_valid);
      s1_rgb[k] = pal_rgb(int'(pix_index));
      s1_lvl[k] = m_level[k];

      m_done[k] = 0;
      moved     = 0;
      if (fade_out_req) begin
        if (m_dir[k] == 1 || (m_dir[k] == 0 && m_level[k] == 16)) begin
          m_dir[k] = -1;
          moved    = 1;
        end
      end else if (fade_in_req) begin
        if (m_dir[k] == -1 || (m_dir[k] == 0 && m_level[k] == 0)) begin
          m_dir[k] = 1;
          moved    = 1;
        end
      end
      if (moved != 0) begin
        m_frames[k] = 0;
      end else if (m_dir[k] != 0 && vsync_pulse) begin
        m_frames[k]++;
        if (m_frames[k] == fps_of(k)) begin
          m_frames[k] = 0;
          m_level[k] += m_dir[k] * step_of(k);
          if (m_level[k] < 0) m_level[k] = 0;
          if (m_level[k] > 16) m_level[k] = 16;
          if (m_level[k] == 0 || m_level[k] == 16) begin
            m_dir[k]  = 0;
            m_done[k] = 1;
          end
        end
      end
    end
    if (flash_req) m_flash = 8;
    else if (vsync_pulse && m_flash > 0) m_flash--;

    if (!Reset_n) begin
      m_flash = 0;
      for (int k = 0; k < 2; k++) begin
        m_level[k]  = 16;
        m_dir[k]    = 0;
        m_frames[k] = 0;
        m_done[k]   = 0;
        s1_v[k]     = 0;
        s2_v[k]     = 0;
        for (int ch = 0; ch < 3; ch++) s2_c[k][ch] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("red[%0d]", k), int'(red[k]), s2_c[k][0]);
      check_eq($sformatf("green[%0d]", k), int'(green[k]), s2_c[k][1]);
      check_eq($sformatf("blue[%0d]", k), int'(blue[k]), s2_c[k][2]);
      check_eq($sformatf("pix_valid_out[%0d]", k), int'(pvo[k]), s2_v[k]);
      check_eq($sformatf("busy[%0d]", k), int'(busy[k]), int'(m_dir[k] != 0));
      check_eq($sformatf("fade_done[%0d]", k), int'(done[k]), m_done[k]);
      if (done[k] === 1'b1) done_cnt[k]++;
    end
  endtask

  task automatic cycle(input bit vs, input bit fo, input bit fi, input bit fl);
    vsync_pulse  = vs;
    fade_out_req = fo;
    fade_in_req  = fi;
    flash_req    = fl;
    if (rand_pix) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_index = 4'($urandom_range(0, 15));
    end
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic frames(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (gap - 1) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic hold_pixel(input int idx);
    rand_pix  = 1'b0;
    pix_valid = 1'b1;
    pix_index = 4'(idx);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rand_pix  = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    vsync_pulse = 1'b0; pix_valid = 1'b0; pix_index = '0;
    fade_out_req = 1'b0; fade_in_req = 1'b0; flash_req = 1'b0;
    m_flash = 0;
    for (int k = 0; k < 2; k++) begin
      m_level[k] = 16; m_dir[k] = 0; m_frames[k] = 0; m_done[k] = 0;
      s1_v[k] = 0; s1_rgb[k] = 0; s1_lvl[k] = 16; s2_v[k] = 0; done_cnt[k] = 0;
      for (int ch = 0; ch < 3; ch++) s2_c[k][ch] = 0;
    end

    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_red", int'(red[0]), 0);
    check_eq("reset_busy", int'(busy[0]), 0);
    Reset_n = 1'b1;
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Idle: full-brightness lookup, then invalid pixel blanks.
    hold_pixel(3);
    check_eq("idle_idx3_r", int'(red[0]), 15);
    check_eq("idle_idx3_g", int'(green[0]), 13);
    check_eq("idle_idx3_b", int'(blue[0]), 7);
    check_eq("idle_idx3_v", int'(pvo[0]), 1);
    rand_pix = 1'b0; pix_valid = 1'b0;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rand_pix = 1'b1;
    check_eq("invalid_r", int'(red[0]), 0);

    // Fade out to level 8, then to black.
    done_cnt[0] = 0; done_cnt[1] = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    frames(16, 4);
    hold_pixel(3);
    check_eq("lvl8_r", int'(red[0]), 7);
    check_eq("lvl8_g", int'(green[0]), 6);
    check_eq("lvl8_b", int'(blue[0]), 3);
    frames(16, 4);
    check_eq("dark_busy", int'(busy[0]), 0);
    check_eq("dark_done_cnt_a", done_cnt[0], 1);
    check_eq("dark_done_cnt_b", done_cnt[1], 1);
    hold_pixel(3);
    check_eq("dark_r", int'(red[0]), 0);

    // Back to full, then reversal at level 10.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    frames(34, 4);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    frames(12, 4);
    done_cnt[0] = 0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("rev_busy", int'(busy[0]), 1);
    frames(12, 4);
    check_eq("rev_idle_busy", int'(busy[0]), 0);
    check_eq("rev_done_cnt", done_cnt[0], 1);

    // Simultaneous requests plus vsync while fading in.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    frames(6, 3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    frames(2, 3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("both_req_busy", int'(busy[0]), 1);
    frames(4, 3);

    // Reset in the middle of a fade at level 5.
    Reset_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    frames(22, 2);
    Reset_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("midrst_r", int'(red[0]), 0);
    check_eq("midrst_v", int'(pvo[0]), 0);
    check_eq("midrst_busy", int'(busy[0]), 0);
    Reset_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Hazard flash.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    hold_pixel(2);
`ifdef PALETTE_FLASH_EN
    check_eq("flash_r", int'(red[0]), 15);
`else
    check_eq("flash_r", int'(red[0]), 6);
`endif
    check_eq("flash_g", int'(green[0]), 13);
    check_eq("flash_b", int'(blue[0]), 15);
    frames(10, 4);
    hold_pixel(2);
    check_eq("postflash_r", int'(red[0]), 6);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      Reset_n = ($urandom_range(0, 299) != 0);
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 79) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
